// File: rtl/weight_loader.sv
// ============================================================================
// Module  : weight_loader
// Brief   : Decodes framed header+weight streams into registered per-neuron
//           weight-memory write strobes for one layer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module weight_loader #(
    parameter int layerNo      = 1,
    parameter int numNeuron    = 30,
    parameter int numWeight    = 784,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [31:0]             s_data,
    input  logic                    s_last,
    output logic [numNeuron-1:0]    wen,
    output logic [addressWidth-1:0] wadd,
    output logic [dataWidth-1:0]    win,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SKIP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [7:0]  c_LAYER      = 8'(layerNo);
    localparam logic [15:0] c_NUM_NEURON = 16'(numNeuron);
    localparam logic [15:0] c_NUM_WEIGHT = 16'(numWeight);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [7:0]                r_neuron;
    logic [15:0]               r_count;
    logic [addressWidth-1:0]   r_addr;
    logic [numNeuron-1:0]      r_wen;
    logic [addressWidth-1:0]   r_wadd;
    logic [dataWidth-1:0]      r_win;
    logic                      r_err;

    logic                      w_hs;
    logic                      w_hdr;
    logic                      w_layer_ok;
    logic                      w_target_ok;
    logic                      w_burst_end;
    logic                      w_write;
    logic                      w_err_set;
    logic [numNeuron-1:0]      w_onehot;

    assign w_hs        = s_valid & s_ready;
    assign w_hdr       = (r_state == ST_IDLE) & w_hs;
    assign w_layer_ok  = (s_data[31:24] == c_LAYER);
    assign w_target_ok = (16'(s_data[23:16]) < c_NUM_NEURON) &&
                         (s_data[15:0] != 16'd0) && (s_data[15:0] <= c_NUM_WEIGHT);
    assign w_burst_end = (16'(r_addr) == (r_count - 16'd1));
    assign w_onehot    = {{(numNeuron-1){1'b0}}, 1'b1} << r_neuron;

    always_comb begin
        w_state_nxt = r_state;
        w_write     = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_hs) begin
                    if (!w_layer_ok) begin
                        w_state_nxt = s_last ? ST_IDLE : ST_SKIP;
                    end else if (!w_target_ok) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = s_last ? ST_IDLE : ST_SKIP;
                    end else if (s_last) begin
                        // legal target but no payload
                        w_err_set   = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (w_hs) begin
                    w_write = 1'b1;
                    if (s_last) begin
                        w_err_set   = !w_burst_end;
                        w_state_nxt = ST_DONE;
                    end else if (w_burst_end) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = ST_SKIP;
                    end
                end
            end
            ST_SKIP: begin
                if (w_hs && s_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neuron <= '0;
            r_count  <= '0;
            r_addr   <= '0;
            r_wen    <= '0;
            r_wadd   <= '0;
            r_win    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_wen <= '0;
            if (w_hdr) begin
                r_neuron <= s_data[23:16];
                r_count  <= s_data[15:0];
                r_addr   <= '0;
            end
            if (w_write) begin
                r_wen  <= w_onehot;
                r_wadd <= r_addr;
                r_win  <= s_data[dataWidth-1:0];
                r_addr <= r_addr + 1'b1;
            end
            // a fresh header clears the sticky flag unless that header is itself bad
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (w_hdr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign s_ready = rst_n & (r_state != ST_DONE);
    assign busy    = (r_state == ST_LOAD) | (r_state == ST_SKIP);
    assign done    = (r_state == ST_DONE);
    assign err     = r_err;
    assign wen     = r_wen;
    assign wadd    = r_wadd;
    assign win     = r_win;

endmodule

`default_nettype wire

// File: tb/tb_weight_loader.sv
// ============================================================================
// Module  : tb_weight_loader
// Brief   : Randomized self-checking bench for weight_loader against a
//           frame-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_weight_loader;

    localparam int c_NN    = 30;
    localparam int c_NW    = 784;
    localparam int c_AW    = 10;
    localparam int c_DW    = 16;
    localparam int c_LAYER = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              s_valid;
    logic              s_ready;
    logic [31:0]       s_data;
    logic              s_last;
    logic [c_NN-1:0]   wen;
    logic [c_AW-1:0]   wadd;
    logic [c_DW-1:0]   win;
    logic              busy;
    logic              done;
    logic              err;

    int errors = 0;
    int checks = 0;
    int gap_pct = 0;
    int done_cnt = 0;

    logic [c_NN-1:0] q_wen[$];
    logic [c_AW-1:0] q_wadd[$];
    logic [c_DW-1:0] q_win[$];

    weight_loader #(
        .layerNo(c_LAYER), .numNeuron(c_NN), .numWeight(c_NW),
        .addressWidth(c_AW), .dataWidth(c_DW)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .wen(wen), .wadd(wadd), .win(win),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wen != '0) begin
            q_wen.push_back(wen);
            q_wadd.push_back(wadd);
            q_win.push_back(win);
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int   waited = 0;
        logic hs = 1'b0;
        while (!hs) begin
            @(negedge clk);
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                s_valid = 1'b0;
                s_data  = $urandom;
                s_last  = $urandom_range(1);
            end else begin
                s_valid = 1'b1;
                s_data  = d;
                s_last  = l;
                #1 hs = s_ready;
            end
            waited++;
            if (!hs && waited > 200) begin
                check("handshake_timeout", 32'd0, 32'd1);
                s_valid = 1'b0;
                return;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic clear_mon();
        q_wen.delete();
        q_wadd.delete();
        q_win.delete();
        done_cnt = 0;
    endtask

    // Expected outcome derived straight from the frame rules
    task automatic run_frame(input string tag, input int layer, input int neuron,
                             input int count, input int nwords, input bit fixed);
        logic [31:0] data[$];
        int exp_n, exp_done;
        bit legal, exp_err;
        clear_mon();
        for (int i = 0; i < nwords; i++)
            data.push_back(fixed ? 32'hA + 32'(i) : $urandom);
        send({8'(layer), 8'(neuron), 16'(count)}, nwords == 0);
        for (int i = 0; i < nwords; i++) send(data[i], i == nwords - 1);
        idle(4);

        legal = (layer == c_LAYER) && (neuron < c_NN) && (count >= 1) && (count <= c_NW);
        if (layer != c_LAYER) begin
            exp_n = 0; exp_err = 0; exp_done = 0;
        end else if (!legal) begin
            exp_n = 0; exp_err = 1; exp_done = 0;
        end else if (nwords == 0) begin
            exp_n = 0; exp_err = 1; exp_done = 1;
        end else begin
            exp_n    = (nwords < count) ? nwords : count;
            exp_err  = (nwords != count);
            exp_done = (nwords <= count) ? 1 : 0;
        end

        check({tag, "_nwrites"}, q_wen.size(), exp_n);
        for (int i = 0; i < exp_n && i < q_wen.size(); i++) begin
            check($sformatf("%s_wen%0d", tag, i), 32'(q_wen[i]), 32'(1) << neuron);
            check($sformatf("%s_wadd%0d", tag, i), 32'(q_wadd[i]), i);
            check($sformatf("%s_win%0d", tag, i), 32'(q_win[i]), 32'(data[i][c_DW-1:0]));
        end
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_done"}, done_cnt, exp_done);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_ready"}, 32'(s_ready), 1);
    endtask

    initial begin
        int kind, cnt, nw, nrn, lay;
        rst_n = 1'b0; s_valid = 1'b1; s_data = 32'h0103_0004; s_last = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(s_ready), 0);
        check("rst_wen", 32'(wen), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1; s_valid = 1'b0;
        #1 check("rel_ready", 32'(s_ready), 1);
        idle(2);

        run_frame("clean", 1, 3, 4, 4, 1'b1);
        run_frame("foreign", 2, 0, 5, 5, 1'b0);
        run_frame("illegal", 1, 32, 2, 2, 1'b0);
        run_frame("legal_after", 1, 4, 3, 3, 1'b0);
        run_frame("short", 1, 2, 3, 2, 1'b0);
        run_frame("long", 1, 6, 2, 5, 1'b0);
        run_frame("empty", 1, 1, 4, 0, 1'b0);
        run_frame("cnt0", 1, 1, 0, 2, 1'b0);
        run_frame("cnt785", 1, 1, 785, 2, 1'b0);
        run_frame("n29", 1, 29, 3, 3, 1'b0);

        gap_pct = 30;
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(3);
            cnt  = $urandom_range(12, 1);
            nrn  = $urandom_range(c_NN - 1);
            lay  = c_LAYER;
            case (kind)
                0: nw = cnt;
                1: nw = (cnt > 1) ? $urandom_range(cnt - 1, 1) : 1;
                2: nw = cnt + $urandom_range(3, 1);
                default: begin
                    nw = $urandom_range(4, 1);
                    if ($urandom_range(1)) lay = $urandom_range(255, 2);
                    else nrn = $urandom_range(255, c_NN);
                end
            endcase
            run_frame($sformatf("rnd%0d", f), lay, nrn, cnt, nw, 1'b0);
        end

        gap_pct = 40;
        run_frame("full", 1, 0, 784, 784, 1'b0);
        check("full_last_wadd", 32'(q_wadd.size() > 0 ? q_wadd[q_wadd.size()-1] : '0), 783);

        // Reset asserted right after the 100th handshake of a long burst
        clear_mon();
        gap_pct = 20;
        send(32'h0105_0310, 1'b0);
        for (int i = 0; i < 100; i++) send(32'(i), 1'b0);
        @(posedge clk);
        #1;
        check("mid_wen_live", 32'(wen), 32'(1) << 5);
        check("mid_wadd_live", 32'(wadd), 99);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_wen", 32'(wen), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_ready", 32'(s_ready), 0);
        check("mid_rst_nwrites", q_wen.size(), 99);
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        check("post_rst_ready", 32'(s_ready), 1);
        check("post_rst_busy", 32'(busy), 0);
        gap_pct = 0;
        run_frame("after_rst", 1, 8, 3, 3, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
